// File: rtl/wolfram_ca_sequencer_if.sv
// rtl/wolfram_ca_sequencer_if.sv - load and row-output handshake bundle for wolfram_ca_sequencer
interface wolfram_ca_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_row;
    logic             row_valid;
    logic             row_ready;
    logic [WIDTH-1:0] row_out;

    modport master (
        output load_valid, load_row, row_ready,
        input  load_ready, row_valid, row_out
    );

    modport slave (
        input  load_valid, load_row, row_ready,
        output load_ready, row_valid, row_out
    );
endinterface

// File: rtl/wolfram_ca_sequencer.sv
// rtl/wolfram_ca_sequencer.sv - elementary CA generation sequencer, one cell per clock; WOLFRAM_CA_WRAP_EN selects wrapped row edges
module wolfram_ca_sequencer #(
    parameter int         WIDTH        = 16,
    parameter int         GEN_W        = 8,
    parameter logic [7:0] RULE_DEFAULT = 8'h5D
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [7:0]       cfg_rule,
    output logic [7:0]       rule,
    input  logic             start,
    input  logic [GEN_W-1:0] gens,
    output logic             busy,
    output logic             done,
    wolfram_ca_sequencer_if.slave bus
);
    localparam int IW = $clog2(WIDTH);
    localparam int XW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {IDLE, RUN, EMIT, FIN} state_t;

    state_t           state;
    logic [WIDTH-1:0] cur_row;
    logic [WIDTH-1:0] next_buf;
    logic [WIDTH-1:0] row_out_q;
    logic [IW-1:0]    idx;
    logic [GEN_W-1:0] remaining;
    logic [7:0]       rule_q;
    logic             row_valid_q;
    logic             done_q;
    logic             busy_q;
    logic             load_ready_q;

    logic             lbound;
    logic             rbound;
    logic [WIDTH+1:0] ext;
    logic [XW-1:0]    xi;
    logic [2:0]       nbhd;
    logic [WIDTH-1:0] next_full;

    // ext is the current row padded with its edge neighbours, so cell i sees {L,C,R} = ext[i+2:i]
    always_comb begin
`ifdef WOLFRAM_CA_WRAP_EN
        lbound = cur_row[0];
        rbound = cur_row[WIDTH-1];
`else
        lbound = 1'b0;
        rbound = 1'b0;
`endif
        ext            = {lbound, cur_row, rbound};
        xi             = XW'(idx);
        nbhd           = ext[xi +: 3];
        next_full      = next_buf;
        next_full[idx] = rule_q[nbhd];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cur_row      <= '0;
            next_buf     <= '0;
            row_out_q    <= '0;
            idx          <= '0;
            remaining    <= '0;
            rule_q       <= RULE_DEFAULT;
            row_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load_valid && load_ready_q) begin
                        cur_row <= bus.load_row;
                    end
                    if (cfg_we) begin
                        rule_q <= cfg_rule;
                    end
                    if (start) begin
                        busy_q       <= 1'b1;
                        load_ready_q <= 1'b0;
                        if (gens != '0) begin
                            remaining <= gens;
                            idx       <= '0;
                            state     <= RUN;
                        end else begin
                            done_q <= 1'b1;
                            state  <= FIN;
                        end
                    end
                end
                RUN: begin
                    next_buf <= next_full;
                    if (idx == IW'(WIDTH - 1)) begin
                        cur_row     <= next_full;
                        row_out_q   <= next_full;
                        row_valid_q <= 1'b1;
                        state       <= EMIT;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                EMIT: begin
                    if (bus.row_ready) begin
                        row_valid_q <= 1'b0;
                        remaining   <= remaining - 1'b1;
                        if (remaining == GEN_W'(1)) begin
                            done_q <= 1'b1;
                            state  <= FIN;
                        end else begin
                            idx   <= '0;
                            state <= RUN;
                        end
                    end
                end
                FIN: begin
                    done_q       <= 1'b0;
                    busy_q       <= 1'b0;
                    load_ready_q <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rule           = rule_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign bus.load_ready = load_ready_q;
    assign bus.row_valid  = row_valid_q;
    assign bus.row_out    = row_out_q;
endmodule

// File: tb/tb_wolfram_ca_sequencer.sv
// tb/tb_wolfram_ca_sequencer.sv - directed table-driven bench for wolfram_ca_sequencer (WIDTH=8)
module tb_wolfram_ca_sequencer;
    localparam int W = 8;
`ifdef WOLFRAM_CA_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_we;
    logic [7:0]   cfg_rule;
    logic [7:0]   rule;
    logic         start;
    logic [7:0]   gens;
    logic         busy;
    logic         done;

    wolfram_ca_sequencer_if #(.WIDTH(W)) bus ();

    wolfram_ca_sequencer #(.WIDTH(W), .GEN_W(8), .RULE_DEFAULT(8'h5D)) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_rule (cfg_rule),
        .rule     (rule),
        .start    (start),
        .gens     (gens),
        .busy     (busy),
        .done     (done),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int t_start = 0;
    int first_valid = -1;
    int last_hs = -1;
    int done_cnt = 0;
    int done_cyc = -1;
    logic [7:0] rows[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.row_valid && first_valid < 0) first_valid = cyc;
        if (bus.row_valid && bus.row_ready) begin
            rows.push_back(bus.row_out);
            last_hs = cyc;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        rows.delete();
        first_valid = -1;
        last_hs = -1;
        done_cnt = 0;
        done_cyc = -1;
    endtask

    task automatic setup(input logic [7:0] r, input logic [7:0] row);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_rule = r;
        bus.load_valid = 1'b1; bus.load_row = row;
        @(posedge clk); #1;
        cfg_we = 1'b0; bus.load_valid = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] g);
        @(posedge clk); #1;
        start = 1'b1; gens = g;
        t_start = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == 0) chk({tag, "_timeout"}, 0, 1);
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] r;
        logic [7:0] row;
        int         g;
        logic [7:0] e0;
        logic [7:0] e1;
    } vec_t;

    vec_t vt[6];

    initial begin
        vt[0] = '{8'h5D, 8'h00, 2, 8'hFF, WRAP ? 8'h00 : 8'h81};
        vt[1] = '{8'hCC, 8'hA5, 1, 8'hA5, 8'h00};
        vt[2] = '{8'hF0, 8'h81, 1, WRAP ? 8'hC0 : 8'h40, 8'h00};
        vt[3] = '{8'hAA, 8'h81, 1, WRAP ? 8'h03 : 8'h02, 8'h00};
        vt[4] = '{8'h96, 8'h10, 2, 8'h38, 8'h54};
        vt[5] = '{8'hFF, 8'h00, 1, 8'hFF, 8'h00};

        rst = 1'b1; cfg_we = 1'b0; cfg_rule = 8'h00; start = 1'b0; gens = 8'h00;
        bus.load_valid = 1'b0; bus.load_row = 8'h00; bus.row_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_rule", int'(rule), 8'h5D);
        chk("reset_load_ready", int'(bus.load_ready), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_row_valid", int'(bus.row_valid), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_row_out", int'(bus.row_out), 0);

        for (int i = 0; i < 6; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            clear_mon();
            setup(vt[i].r, vt[i].row);
            chk({tag, "_rule"}, int'(rule), int'(vt[i].r));
            do_start(vt[i].g[7:0]);
            wait_done(tag);
            chk({tag, "_latency"}, first_valid - t_start, W + 1);
            chk({tag, "_nrows"}, rows.size(), vt[i].g);
            if (rows.size() > 0) chk({tag, "_row0"}, int'(rows[0]), int'(vt[i].e0));
            if (vt[i].g > 1 && rows.size() > 1) chk({tag, "_row1"}, int'(rows[1]), int'(vt[i].e1));
            chk({tag, "_done_cnt"}, done_cnt, 1);
            chk({tag, "_done_timing"}, done_cyc - last_hs, 1);
        end

        // stall during the first EMIT of a two-generation run
        clear_mon();
        setup(8'h5D, 8'h00);
        bus.row_ready = 1'b0;
        do_start(8'd2);
        begin
            int n = 0;
            while (!bus.row_valid && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
        end
        for (int k = 0; k < 5; k++) begin
            chk("stall_row_valid", int'(bus.row_valid), 1);
            chk("stall_row_out", int'(bus.row_out), 8'hFF);
            @(posedge clk); #1;
        end
        chk("stall_no_handshake", rows.size(), 0);
        bus.row_ready = 1'b1;
        wait_done("stall");
        chk("stall_nrows", rows.size(), 2);
        if (rows.size() > 1) chk("stall_row1", int'(rows[1]), WRAP ? 8'h00 : 8'h81);
        chk("stall_done_cnt", done_cnt, 1);

        // config, start and load are ignored while busy
        clear_mon();
        setup(8'h5D, 8'h00);
        do_start(8'd2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_rule = 8'h00; start = 1'b1; gens = 8'd5;
        bus.load_valid = 1'b1; bus.load_row = 8'h3C;
        chk("busy_load_ready", int'(bus.load_ready), 0);
        chk("busy_flag", int'(busy), 1);
        @(posedge clk); #1;
        cfg_we = 1'b0; start = 1'b0; bus.load_valid = 1'b0;
        wait_done("busy");
        chk("busy_rule", int'(rule), 8'h5D);
        chk("busy_nrows", rows.size(), 2);
        if (rows.size() > 0) chk("busy_row0", int'(rows[0]), 8'hFF);
        if (rows.size() > 1) chk("busy_row1", int'(rows[1]), WRAP ? 8'h00 : 8'h81);

        // zero-generation run
        clear_mon();
        do_start(8'd0);
        chk("gens0_done_now", int'(done), 1);
        wait_done("gens0");
        chk("gens0_done_timing", done_cyc - t_start, 1);
        chk("gens0_done_cnt", done_cnt, 1);
        chk("gens0_nrows", rows.size(), 0);
        chk("gens0_no_valid", first_valid, -1);

        // reset in the middle of RUN
        clear_mon();
        setup(8'hCC, 8'hA5);
        do_start(8'd3);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_row_out", int'(bus.row_out), 0);
        chk("rst_rule", int'(rule), 8'h5D);
        chk("rst_load_ready", int'(bus.load_ready), 1);
        chk("rst_row_valid", int'(bus.row_valid), 0);
        repeat (40) @(negedge clk);
        chk("rst_no_done", done_cnt, 0);
        chk("rst_no_rows", rows.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/wolfram_ca_sequencer.md
Name: wolfram_ca_sequencer

Overview:
- Sequences a single 3-input rule-table evaluator across a WIDTH-cell row, one cell per clock, to compute successive generations of an elementary cellular automaton.
- The 8-bit rule table is a runtime-configurable register, so any 3-input truth-table function in the library can be swept across a row.
- Sits between a host loader and a downstream row consumer with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 16, number of cells per row; minimum 3.
- GEN_W, 8, width of the generation-count input and counter.
- RULE_DEFAULT, 8'h5D, rule register value after reset.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- cfg_we  input  1  rule write strobe; honoured only in IDLE.
- cfg_rule  input  8  new rule value.
- rule  output  8  current rule register.
- load_valid  input  1  host offers an initial row.
- load_ready  output  1  high only in IDLE.
- load_row  input  WIDTH  initial row; accepted when load_valid and load_ready are both high.
- start  input  1  begin a run; honoured only in IDLE.
- gens  input  GEN_W  number of generations to compute; sampled with start.
- busy  output  1  high in any state other than IDLE.
- row_valid  output  1  computed generation available.
- row_ready  input  1  consumer accepts row_out.
- row_out  output  WIDTH  most recently completed generation.
- done  output  1  one-cycle pulse when a run finishes.

Behaviour:
- Reset:
  - State goes to IDLE; current row, next-row buffer and row_out are cleared to 0.
  - rule = RULE_DEFAULT; row_valid, done and busy = 0; load_ready = 1.
  - Reset asserted mid-run aborts the run; no done pulse is produced.
- Cell rule:
  - For cell i: L = row[i+1], C = row[i], R = row[i-1].
  - next[i] = rule[{L,C,R}], where index 0 corresponds to 000.
  - Out-of-range neighbours (L of cell WIDTH-1, R of cell 0) read 0 by default; see the optional feature.
- States: IDLE, RUN, EMIT, FIN.
- IDLE:
  - A load handshake copies load_row into the current row.
  - cfg_we updates rule.
  - If load and cfg_we occur in the same cycle, both take effect.
  - start with gens != 0 latches gens into the remaining counter, clears the cell index and moves to RUN.
  - start with gens == 0 moves to FIN.
  - If start coincides with a load, the newly loaded row is used.
- RUN:
  - One cell per cycle, index 0 up to WIDTH-1, written into the next-row buffer.
  - Neighbours are always read from the unmodified current row, never the partially written buffer.
  - After the cycle with index WIDTH-1: current row and row_out take the buffer, state moves to EMIT.
- EMIT:
  - row_valid = 1; row_out is held stable until the row_ready handshake.
  - On handshake the remaining counter is decremented. If it reaches 0, go to FIN; otherwise clear the index and go to RUN.
- FIN: done = 1 for exactly one cycle, then IDLE.
- Timing:
  - start accepted at cycle T gives row_valid first high at T+WIDTH+1.
  - Each additional generation adds WIDTH cycles plus the EMIT stall.
- While busy:
  - cfg_we, start and load_valid are ignored; load_ready = 0.
  - The rule cannot change mid-run.

Optional Feature:
- Macro: WOLFRAM_CA_WRAP_EN.
- Defined: boundary wraps. L of cell WIDTH-1 reads row[0], and R of cell 0 reads row[WIDTH-1].
- Undefined: both out-of-range neighbours read constant 0.

Test Plan (WIDTH=8 unless noted):
- Reset, then load 0x00, start with gens=2, row_ready=1 -> rule = 0x5D; rows emitted 0xFF then 0x81 (no wrap); one done pulse; first row_valid at T+9.
- cfg_rule=0xCC, load 0xA5, gens=1 -> row_out = 0xA5 (identity rule); done one cycle after handshake.
- cfg_rule=0xF0, load 0x81, gens=1 -> 0x40 without WOLFRAM_CA_WRAP_EN; 0xC0 with it.
- Hold row_ready=0 for 5 cycles during the first EMIT of a gens=2 run -> row_out and row_valid stable; second generation starts only after the handshake; total rows = 2.
- While busy, pulse cfg_we with 0x00, start, and load_valid -> rule still 0x5D, load_ready = 0, the run completes unchanged; start with gens=0 in IDLE -> done at T+1, no row_valid.
- Assert rst in the middle of RUN -> next cycle: IDLE, busy=0, row_out=0, rule=0x5D, no done pulse.
